msg_dispatch: RTL and testbench
===============================

MSG_DISPATCH -- requirements
Module: msg_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the payload width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the source presents a message.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the message this cycle.
REQ-006 The block SHALL have port in_dest, input, 2 bits: destination; 00 = ceo, 01 = you, 10 = fred, 11 = jill.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: message payload.
REQ-008 The block SHALL have ports ceo, you, fred and jill, output, DATA_W bits each: the per-destination mailbox contents.
REQ-009 The block SHALL have port out_valid, output, 4 bits: mailbox full flags, with bit index equal to the dest code.
REQ-010 The block SHALL have port out_ack, input, 4 bits: consumer takes the mailbox; it is honoured only when the matching out_valid bit is 1.
REQ-011 The block SHALL have port stall_cnt, output, 8 bits: saturating count of stalled cycles.
REQ-012 The block SHALL have port stall_clr, input, 1 bit: synchronous clear of stall_cnt.

Function
REQ-013 Each mailbox SHALL be a two-state FSM, EMPTY or FULL, with out_valid[i] = 1 exactly in FULL.
REQ-014 in_ready SHALL be combinational: ~out_valid[in_dest] | out_ack[in_dest], independent of in_valid.
REQ-015 A transfer SHALL occur when in_valid and in_ready are both 1; on the next edge the mailbox at in_dest loads in_data and goes FULL, giving 1-cycle latency.
REQ-016 An out_ack[i] without a same-cycle write to mailbox i SHALL move it to EMPTY on the next edge; its data output holds its last value.
REQ-017 A simultaneous ack and write to the same mailbox SHALL load the new data and keep the mailbox FULL, sustaining one message per cycle.
REQ-018 Writes and acks on different mailboxes SHALL proceed independently in the same cycle.
REQ-019 A stall, in_valid = 1 and in_ready = 0, SHALL increment stall_cnt by 1, saturating at 255.
REQ-020 stall_clr SHALL take priority over increment, so stall_cnt becomes 0 on the next edge.
REQ-021 While in_valid = 0 the block SHALL ignore in_data and in_dest and change no mailbox.

Reset
REQ-022 On assertion of rst_n = 0 the block SHALL immediately force all mailboxes to EMPTY, out_valid = 0000, ceo/you/fred/jill = 0, and stall_cnt = 0.
REQ-023 A message in flight when reset asserts SHALL be discarded, and no write SHALL occur on the first edge after deassertion unless a handshake is valid in that cycle.

Configuration
REQ-024 When macro MSG_DISPATCH_BROADCAST_EN is defined, the block SHALL have an input port in_bcast, 1 bit.
REQ-025 With the macro defined and in_bcast = 1, in_ready SHALL equal the AND over all i of (~out_valid[i] | out_ack[i]), and a transfer SHALL load all four mailboxes with in_data; in_dest is ignored.
REQ-026 Without the macro, the block SHALL have no in_bcast port and no broadcast logic, and REQ-014 SHALL apply unchanged.

Structure
REQ-027 Package msg_dispatch_pkg SHALL hold the dest constants DEST_CEO/YOU/FRED/JILL (00/01/10/11), the mailbox state enum (EMPTY, FULL) and STALL_MAX = 255.
REQ-028 The block SHALL instantiate sub-module msg_mailbox four times; each instance holds one slot with ports wr, ack, data in, data out and valid.
REQ-029 The stall counter and ready decode SHALL stay in msg_dispatch.

Verification
REQ-030 Reset, then write dest 10 with data 0xA: the next cycle fred = 0xA and out_valid = 0100; all other outputs stay 0.
REQ-031 With fred FULL and no ack, present dest 10 for 5 cycles: in_ready = 0 throughout, stall_cnt = 5, and fred is unchanged.
REQ-032 With fred FULL, ack and write dest 10 with 0x3 in the same cycle: in_ready = 1, fred = 0x3 next cycle, and out_valid[2] stays 1.
REQ-033 Stall for 300 cycles: stall_cnt = 255; assert stall_clr together with a stall: stall_cnt = 0 next cycle.
REQ-034 Assert rst_n low mid-transfer to ceo: all outputs are 0 immediately, and after release out_valid = 0000.
REQ-035 With MSG_DISPATCH_BROADCAST_EN, in_bcast = 1, data 0x5 and all mailboxes EMPTY: all four outputs = 0x5 and out_valid = 1111; with jill FULL and unacked, in_ready = 0.

Source files
------------

// File: rtl/msg_dispatch_pkg.sv
// Shared constants and types for the message dispatcher.
package msg_dispatch_pkg;

   localparam logic [1:0] DEST_CEO  = 2'b00;
   localparam logic [1:0] DEST_YOU  = 2'b01;
   localparam logic [1:0] DEST_FRED = 2'b10;
   localparam logic [1:0] DEST_JILL = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } mbox_state_t;

   localparam logic [7:0] STALL_MAX = 8'd255;

endpackage

// File: rtl/msg_mailbox.sv
// One-slot mailbox: EMPTY/FULL FSM holding the last written payload.
module msg_mailbox
   import msg_dispatch_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              ack,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              valid
);

   mbox_state_t state;

   // A write wins over an ack so back-to-back traffic keeps the slot full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         dout  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (wr) begin
                  state <= FULL;
                  dout  <= din;
               end
            end
            FULL: begin
               if (wr) begin
                  dout <= din;
               end else if (ack) begin
                  state <= EMPTY;
               end
            end
         endcase
      end
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/msg_dispatch.sv
// Routes messages into four mailboxes and counts stalled cycles.
// Optional broadcast mode: define MSG_DISPATCH_BROADCAST_EN.
module msg_dispatch
   import msg_dispatch_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_dest,
   input  logic [DATA_W-1:0] in_data,
`ifdef MSG_DISPATCH_BROADCAST_EN
   input  logic              in_bcast,
`endif
   output logic [DATA_W-1:0] ceo,
   output logic [DATA_W-1:0] you,
   output logic [DATA_W-1:0] fred,
   output logic [DATA_W-1:0] jill,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ack,
   output logic [7:0]        stall_cnt,
   input  logic              stall_clr
);

   logic [3:0]        free;
   logic [3:0]        dec;
   logic [3:0]        sel;
   logic [3:0]        wr;
   logic              take;
   logic [DATA_W-1:0] mbox [4];

   // A slot can take data if empty or being drained this cycle.
   assign free = ~out_valid | out_ack;
   assign dec  = 4'b0001 << in_dest;

`ifdef MSG_DISPATCH_BROADCAST_EN
   assign in_ready = in_bcast ? &free : free[in_dest];
   assign sel      = in_bcast ? 4'hF : dec;
`else
   assign in_ready = free[in_dest];
   assign sel      = dec;
`endif

   assign take = in_valid & in_ready;
   assign wr   = {4{take}} & sel;

   for (genvar i = 0; i < 4; i++) begin : g_mbox
      msg_mailbox #(
         .DATA_W(DATA_W)
      ) u_mbox (
         .clk  (clk),
         .rst_n(rst_n),
         .wr   (wr[i]),
         .ack  (out_ack[i]),
         .din  (in_data),
         .dout (mbox[i]),
         .valid(out_valid[i])
      );
   end

   assign ceo  = mbox[DEST_CEO];
   assign you  = mbox[DEST_YOU];
   assign fred = mbox[DEST_FRED];
   assign jill = mbox[DEST_JILL];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && stall_cnt != STALL_MAX) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_msg_dispatch.sv
// Directed bench for msg_dispatch with a mailbox-level reference model.
module tb_msg_dispatch;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_dest;
   logic [DW-1:0] in_data;
   logic          in_bcast;
   logic [DW-1:0] ceo, you, fred, jill;
   logic [3:0]    out_valid;
   logic [3:0]    out_ack;
   logic [7:0]    stall_cnt;
   logic          stall_clr;
   logic          bc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   msg_dispatch #(.DATA_W(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dest  (in_dest),
      .in_data  (in_data),
`ifdef MSG_DISPATCH_BROADCAST_EN
      .in_bcast (in_bcast),
`endif
      .ceo      (ceo),
      .you      (you),
      .fred     (fred),
      .jill     (jill),
      .out_valid(out_valid),
      .out_ack  (out_ack),
      .stall_cnt(stall_cnt),
      .stall_clr(stall_clr)
   );

`ifdef MSG_DISPATCH_BROADCAST_EN
   assign bc = in_bcast;
`else
   assign bc = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: each mailbox is a full flag plus stored payload.
   logic [3:0]    m_full;
   logic [DW-1:0] m_data [4];
   int            m_stall;
   logic          m_rdy;
   logic [3:0]    m_wr;

   always_comb begin
      m_rdy = 1'b1;
      m_wr  = '0;
      for (int i = 0; i < 4; i++) begin
         if ((bc || in_dest == 2'(i)) && m_full[i] && !out_ack[i])
            m_rdy = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (in_valid && m_rdy && (bc || in_dest == 2'(i)))
            m_wr[i] = 1'b1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_full  <= '0;
         m_stall <= 0;
         for (int i = 0; i < 4; i++) m_data[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_wr[i]) begin
               m_full[i] <= 1'b1;
               m_data[i] <= in_data;
            end else if (out_ack[i]) begin
               m_full[i] <= 1'b0;
            end
         end
         if (stall_clr) m_stall <= 0;
         else if (in_valid && !m_rdy && m_stall < 255) m_stall <= m_stall + 1;
      end
   end

   always @(negedge clk) begin
      check("in_ready", 32'(in_ready), 32'(m_rdy));
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("ceo", 32'(ceo), 32'(m_data[0]));
      check("you", 32'(you), 32'(m_data[1]));
      check("fred", 32'(fred), 32'(m_data[2]));
      check("jill", 32'(jill), 32'(m_data[3]));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      out_ack   = '0;
      stall_clr = 1'b0;
   endtask

   task automatic send(input logic [1:0] d, input logic [DW-1:0] v);
      in_valid = 1'b1;
      in_dest  = d;
      in_data  = v;
   endtask

   initial begin
      rst_n   = 1'b0;
      in_dest = '0;
      in_data = '0;
      idle();
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst stall", 32'(stall_cnt), 32'h0);

      // Single write to fred
      send(2'b10, 4'hA);
      #1 check("fred ready", 32'(in_ready), 32'h1);
      cyc();
      idle();
      check("fred data", 32'(fred), 32'hA);
      check("fred valid", 32'(out_valid), 32'b0100);
      check("ceo zero", 32'(ceo), 32'h0);

      // Blocked on full fred
      send(2'b10, 4'h7);
      for (int i = 0; i < 5; i++) begin
         #1 check("blocked ready", 32'(in_ready), 32'h0);
         cyc();
      end
      idle();
      check("stall5", 32'(stall_cnt), 32'd5);
      check("fred held", 32'(fred), 32'hA);

      // Ack and write in the same cycle
      send(2'b10, 4'h3);
      out_ack = 4'b0100;
      #1 check("ackwr ready", 32'(in_ready), 32'h1);
      cyc();
      idle();
      check("fred new", 32'(fred), 32'h3);
      check("fred still full", 32'(out_valid[2]), 32'h1);

      // Ignored inputs while idle, ack on an empty slot
      in_dest = 2'b11;
      in_data = 4'hE;
      out_ack = 4'b1000;
      cyc();
      idle();
      check("idle jill", 32'(out_valid), 32'b0100);

      // Independent ack on fred and write to ceo
      send(2'b00, 4'h9);
      out_ack = 4'b0100;
      cyc();
      idle();
      check("indep valid", 32'(out_valid), 32'b0001);
      check("indep ceo", 32'(ceo), 32'h9);
      check("indep fred", 32'(fred), 32'h3);

      send(2'b01, 4'h1); cyc();
      send(2'b11, 4'hC); cyc();
      idle();
      check("all but fred", 32'(out_valid), 32'b1011);

      // Saturation and clear
      stall_clr = 1'b1;
      cyc();
      stall_clr = 1'b0;
      send(2'b00, 4'h2);
      repeat (300) cyc();
      check("stall sat", 32'(stall_cnt), 32'd255);
      stall_clr = 1'b1;
      cyc();
      check("stall clr", 32'(stall_cnt), 32'd0);
      idle();

      // Reset asserted while a ceo transfer is in flight
      out_ack = 4'b0001;
      send(2'b00, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      check("rst valid", 32'(out_valid), 32'h0);
      check("rst outs", 32'({ceo, you, fred, jill}), 32'h0);
      check("rst stall2", 32'(stall_cnt), 32'h0);
      cyc();
      idle();
      rst_n = 1'b1;
      cyc();
      check("post rst", 32'(out_valid), 32'h0);

`ifdef MSG_DISPATCH_BROADCAST_EN
      send(2'b01, 4'h5);
      in_bcast = 1'b1;
      cyc();
      idle();
      check("bc outs", 32'({ceo, you, fred, jill}), 32'h5555);
      check("bc valid", 32'(out_valid), 32'hF);
      send(2'b00, 4'h6);
      in_bcast = 1'b1;
      out_ack  = 4'b0111;
      #1 check("bc blocked", 32'(in_ready), 32'h0);
      cyc();
      idle();
      check("bc jill", 32'(out_valid), 32'b1000);
`endif

      repeat (3) cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
